// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read path: command encodings and engine states.
package sdram_pkg;

   // {CS_n, RAS_n, CAS_n, WE_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_READ = 4'b0101;
   localparam logic [3:0] CMD_PRE  = 4'b0010;

   localparam int A10_BIT = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACT,
      ST_TRCDW,
      ST_RD,
      ST_DRAIN,
      ST_PRE
   } rd_state_e;

endpackage

// File: rtl/sdram_rd_capture.sv
// Tracks in-flight READ bursts and registers returned words into the FIFO
// write port exactly BURST cycles per READ, one cycle after the word is on DQ.
module sdram_rd_capture
   import sdram_pkg::*;
#(
   parameter int CAS_LAT = 3,
   parameter int BURST   = 4
) (
   input  logic        sclk,
   input  logic        s_rst,
   input  logic        issue_i,
   input  logic [15:0] rd_data_i,
   output logic        wr_en_o,
   output logic [15:0] wr_data_o
);

   localparam int DEPTH = CAS_LAT + BURST;

   // vld_q[i] is set i cycles after the READ appears on the command bus
   logic [DEPTH-1:0] vld_q;
   logic             word_valid;
   logic             wr_en_q;
   logic [15:0]      wr_data_q;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_vld
         if (gi == 0) begin : g_head
            always_ff @(posedge sclk) begin
               if (s_rst) vld_q[gi] <= 1'b0;
               else       vld_q[gi] <= issue_i;
            end
         end else begin : g_tail
            always_ff @(posedge sclk) begin
               if (s_rst) vld_q[gi] <= 1'b0;
               else       vld_q[gi] <= vld_q[gi-1];
            end
         end
      end
   endgenerate

   assign word_valid = |vld_q[DEPTH-1:CAS_LAT];

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         wr_en_q   <= 1'b0;
         wr_data_q <= 16'h0000;
      end else begin
         wr_en_q <= word_valid;
         if (word_valid) wr_data_q <= rd_data_i;
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_data_o = wr_data_q;

endmodule

// File: rtl/sdram_read_ctrl.sv
// SDRAM read engine: requests the bus, opens a row, streams bursts across it,
// yields to refresh or a full FIFO at burst boundaries and resumes later.
module sdram_read_ctrl
   import sdram_pkg::*;
#(
   parameter int ROW_W   = 13,
   parameter int COL_W   = 9,
   parameter int BURST   = 4,
   parameter int CAS_LAT = 3,
   parameter int TRCD    = 2
) (
   input  logic             sclk,
   input  logic             s_rst,
   input  logic             rd_trig,
   output logic             rd_req,
   input  logic             rd_en,
   input  logic             ref_req,
   output logic             flag_rd_end,
   output logic [3:0]       rd_cmd,
   output logic [ROW_W-1:0] rd_addr,
   output logic [1:0]       bank_addr,
   input  logic [15:0]      rd_data,
   input  logic             rfifo_full,
   output logic             rfifo_wr_en,
   output logic [15:0]      rfifo_wr_data
);

   localparam int CNT_W = 8;

   rd_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             pending_q, pending_d;
   logic             row_done_q, row_done_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [ROW_W-1:0] addr_q, addr_d;
   logic             flag_q, flag_d;

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         pending_q  <= 1'b0;
         row_done_q <= 1'b0;
         cmd_q      <= CMD_NOP;
         addr_q     <= '0;
         flag_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_q      <= col_d;
         row_q      <= row_d;
         pending_q  <= pending_d;
         row_done_q <= row_done_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         flag_q     <= flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_d      = col_q;
      row_d      = row_q;
      pending_d  = pending_q;
      row_done_d = row_done_q;
      cmd_d      = CMD_NOP;
      addr_d     = '0;
      flag_d     = 1'b0;

      if (rd_trig && !rfifo_full) pending_d = 1'b1;

      case (state_q)
         ST_IDLE: if (pending_q) state_d = ST_REQ;
         ST_REQ:  if (rd_en) state_d = ST_ACT;
         ST_ACT: begin
            cnt_d   = '0;
            state_d = (TRCD > 1) ? ST_TRCDW : ST_RD;
         end
         ST_TRCDW: begin
            if (cnt_q == CNT_W'(TRCD - 2)) begin
               cnt_d   = '0;
               state_d = ST_RD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RD: begin
            if (cnt_q == CNT_W'(BURST - 1)) begin
               col_d = col_q + COL_W'(BURST);
               cnt_d = '0;
               if (col_d == '0 || ref_req || rfifo_full) begin
                  row_done_d = (col_d == '0);
                  state_d    = ST_DRAIN;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_W'(CAS_LAT)) begin
               cnt_d   = '0;
               state_d = ST_PRE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRE: begin
            state_d = ST_IDLE;
            if (row_done_q) begin
               row_d      = row_q + 1'b1;
               pending_d  = 1'b0;
               row_done_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Command and address registers hold the command of the state being entered
      case (state_d)
         ST_ACT: begin
            cmd_d  = CMD_ACT;
            addr_d = row_q;
         end
         ST_RD: begin
            if (cnt_d == '0) begin
               cmd_d              = CMD_READ;
               addr_d[COL_W-1:0]  = col_d;
               addr_d[A10_BIT]    = 1'b0;
            end
         end
         ST_PRE: begin
            cmd_d           = CMD_PRE;
            addr_d[A10_BIT] = 1'b1;
            flag_d          = 1'b1;
         end
         default: ;
      endcase
   end

   sdram_rd_capture #(
      .CAS_LAT (CAS_LAT),
      .BURST   (BURST)
   ) u_capture (
      .sclk      (sclk),
      .s_rst     (s_rst),
      .issue_i   (cmd_d == CMD_READ),
      .rd_data_i (rd_data),
      .wr_en_o   (rfifo_wr_en),
      .wr_data_o (rfifo_wr_data)
   );

   assign rd_req      = (state_q == ST_REQ);
   assign rd_cmd      = cmd_q;
   assign rd_addr     = addr_q;
   assign bank_addr   = 2'b00;
   assign flag_rd_end = flag_q;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Directed bench for sdram_read_ctrl with an 8-word row (COL_W=3).
module tb_sdram_read_ctrl;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] ACT  = 4'b0011;
   localparam logic [3:0] READ = 4'b0101;
   localparam logic [3:0] PRE  = 4'b0010;

   logic        sclk = 1'b0;
   logic        s_rst = 1'b1;
   logic        rd_trig = 1'b0;
   logic        rd_req;
   logic        rd_en = 1'b0;
   logic        ref_req = 1'b0;
   logic        flag_rd_end;
   logic [3:0]  rd_cmd;
   logic [12:0] rd_addr;
   logic [1:0]  bank_addr;
   logic [15:0] rd_data = 16'h0000;
   logic        rfifo_full = 1'b0;
   logic        rfifo_wr_en;
   logic [15:0] rfifo_wr_data;

   int n_checks = 0;
   int n_err    = 0;
   logic [15:0] wa [8];

   always #5 sclk = ~sclk;

   sdram_read_ctrl #(.COL_W(3)) dut (
      .sclk          (sclk),
      .s_rst         (s_rst),
      .rd_trig       (rd_trig),
      .rd_req        (rd_req),
      .rd_en         (rd_en),
      .ref_req       (ref_req),
      .flag_rd_end   (flag_rd_end),
      .rd_cmd        (rd_cmd),
      .rd_addr       (rd_addr),
      .bank_addr     (bank_addr),
      .rd_data       (rd_data),
      .rfifo_full    (rfifo_full),
      .rfifo_wr_en   (rfifo_wr_en),
      .rfifo_wr_data (rfifo_wr_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic trig();
      rd_trig = 1'b1;
      tick();
      rd_trig = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 20 && !rd_req; i++) tick();
      check(tag, rd_req, 1'b1);
      $display("txn %s: rd_req seen", tag);
   endtask

   // Grant, then expect ACT row, one tRCD NOP and the READ at col
   task automatic grant_to_read(input string tag, input logic [12:0] row, input logic [12:0] col);
      rd_en = 1'b1;
      tick();
      check({tag, " act cmd"}, rd_cmd, ACT);
      check({tag, " act row"}, rd_addr, row);
      check({tag, " req low"}, rd_req, 1'b0);
      tick();
      check({tag, " trcd nop"}, rd_cmd, NOP);
      tick();
      check({tag, " read cmd"}, rd_cmd, READ);
      check({tag, " read col"}, rd_addr, col);
      $display("txn %s: ACT row %0d READ col %0d", tag, row, col);
   endtask

   // Single burst followed by DRAIN and PRE; mode 1 raises ref_req, 2 raises rfifo_full
   task automatic burst_to_pre(input string tag, input logic [15:0] base, input int mode);
      int  j;
      logic exp_wr;
      for (int k = 1; k <= 9; k++) begin
         j = k - 1;
         if (k == 2 && mode == 1) ref_req = 1'b1;
         if (k == 2 && mode == 2) rfifo_full = 1'b1;
         rd_data = (j >= 3 && j <= 6) ? base + 16'(j - 3) : 16'h0000;
         tick();
         exp_wr = (k >= 4 && k <= 7);
         check({tag, " wr_en"}, rfifo_wr_en, exp_wr);
         if (exp_wr) check({tag, " wr_data"}, rfifo_wr_data, base + 16'(k - 4));
         check({tag, " cmd"}, rd_cmd, (k == 8) ? PRE : NOP);
         if (k == 8) check({tag, " pre a10"}, rd_addr, 13'h0400);
         check({tag, " flag"}, flag_rd_end, k == 8);
      end
      rd_en = 1'b0;
      $display("txn %s: burst base %h drained, PRE issued", tag, base);
   endtask

   task automatic phase_full_row();
      int   j;
      logic exp_wr;
      for (int k = 1; k <= 13; k++) begin
         j = k - 1;
         rd_data = (j >= 3 && j <= 10) ? wa[j-3] : 16'h0000;
         tick();
         exp_wr = (k >= 4 && k <= 11);
         check("row wr_en", rfifo_wr_en, exp_wr);
         if (exp_wr) check("row wr_data", rfifo_wr_data, wa[k-4]);
         if (k == 4) begin
            check("row read2 cmd", rd_cmd, READ);
            check("row read2 col", rd_addr, 13'd4);
         end else if (k == 12) begin
            check("row pre cmd", rd_cmd, PRE);
            check("row pre a10", rd_addr, 13'h0400);
            check("row bank", bank_addr, 2'b00);
         end else begin
            check("row nop", rd_cmd, NOP);
         end
         check("row flag", flag_rd_end, k == 12);
      end
      rd_en = 1'b0;
      $display("txn full row: 8 words, PRE");
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      logic seen_req = 1'b0;
      logic seen_wr  = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         seen_req |= rd_req;
         seen_wr  |= rfifo_wr_en;
      end
      check({tag, " no req"}, seen_req, 1'b0);
      check({tag, " no wr"}, seen_wr, 1'b0);
      $display("txn %s: quiet for %0d cycles", tag, cycles);
   endtask

   initial begin
      wa[0] = 16'h0f10; wa[1] = 16'h0f55; wa[2] = 16'h0faa; wa[3] = 16'h0f01;
      wa[4] = 16'h1234; wa[5] = 16'h5678; wa[6] = 16'h9abc; wa[7] = 16'hdef0;

      // Reset state
      repeat (3) tick();
      s_rst = 1'b0;
      tick();
      check("rst cmd", rd_cmd, NOP);
      check("rst addr", rd_addr, 13'h0);
      check("rst bank", bank_addr, 2'b00);
      check("rst req", rd_req, 1'b0);
      check("rst flag", flag_rd_end, 1'b0);
      check("rst wr_en", rfifo_wr_en, 1'b0);
      check("rst wr_data", rfifo_wr_data, 16'h0);
      $display("txn reset: outputs idle");

      // One grant reads the whole 8-word row 0
      trig();
      tick();
      check("trig req", rd_req, 1'b1);
      tick();
      tick();
      grant_to_read("row0", 13'd0, 13'd0);
      phase_full_row();
      expect_quiet("after row", 10);

      // Trigger while FIFO full is dropped
      rfifo_full = 1'b1;
      trig();
      expect_quiet("full trig", 20);
      rfifo_full = 1'b0;
      expect_quiet("full dropped", 20);

      // Next trigger opens row 1; reset aborts it
      trig();
      wait_req("row1 req");
      rd_en = 1'b1;
      tick();
      check("row1 act", rd_cmd, ACT);
      check("row1 addr", rd_addr, 13'd1);
      s_rst = 1'b1;
      rd_en = 1'b0;
      tick();
      s_rst = 1'b0;
      check("abort act cmd", rd_cmd, NOP);
      expect_quiet("abort act", 5);

      // Refresh yields after first burst, then resumes at col 4 of row 0
      trig();
      wait_req("ref req1");
      grant_to_read("ref", 13'd0, 13'd0);
      burst_to_pre("ref", 16'h1000, 1);
      wait_req("ref resume");
      ref_req = 1'b0;
      grant_to_read("resume", 13'd0, 13'd4);
      burst_to_pre("resume", 16'h2000, 0);
      expect_quiet("row0 done", 10);

      // FIFO full mid-burst on row 1: burst completes, then PRE
      trig();
      wait_req("fifo req");
      grant_to_read("fifo", 13'd1, 13'd0);
      burst_to_pre("fifo", 16'h3000, 2);
      rfifo_full = 1'b0;
      wait_req("fifo resume");

      // Reset during RD aborts at once
      grant_to_read("rst rd", 13'd1, 13'd4);
      tick();
      s_rst = 1'b1;
      tick();
      check("rd rst cmd", rd_cmd, NOP);
      check("rd rst addr", rd_addr, 13'h0);
      check("rd rst req", rd_req, 1'b0);
      check("rd rst flag", flag_rd_end, 1'b0);
      check("rd rst wr_en", rfifo_wr_en, 1'b0);
      rd_en = 1'b0;
      s_rst = 1'b0;
      expect_quiet("rd rst", 12);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
